// File: rtl/data_mem_ctrl.sv
// Data memory controller for the MEM stage: four byte-wide banks behind a
// small IDLE/BUSY/DONE sequencer that holds the pipeline for the access time.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte-lane storage; never cleared by reset.
  logic [7:0] bank0 [DEPTH];
  logic [7:0] bank1 [DEPTH];
  logic [7:0] bank2 [DEPTH];
  logic [7:0] bank3 [DEPTH];

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        data_q, data_d;
  logic               access_c;

  // Address bits outside the word index alias and are deliberately dropped.
  logic unused_c;
  assign unused_c = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  // The access fires on the last BUSY edge unless the request was flushed.
  assign access_c = (state_q == BUSY) && ce && (cnt_q == '0);

  // Stall while a request is being accepted or is in flight; silent in reset.
  assign stallreq = rst && (((state_q == IDLE) && ce) || (state_q == BUSY));

  assign data_o = data_q;

  // Next-state, request latch, wait countdown and load data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (ce) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          we_d    = we;
          idx_d   = addr[DEPTH_LOG2+1:2];
          sel_d   = sel;
          wdata_d = data_i;
        end
      end
      BUSY: begin
        if (!ce) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (!we_q) begin
            data_d = {bank3[idx_q], bank2[idx_q], bank1[idx_q], bank0[idx_q]};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // Byte-enabled store into the banks on the access edge.
  always_ff @(posedge clk) begin
    if (rst && access_c && we_q) begin
      if (sel_q[0]) bank0[idx_q] <= wdata_q[7:0];
      if (sel_q[1]) bank1[idx_q] <= wdata_q[15:8];
      if (sel_q[2]) bank2[idx_q] <= wdata_q[23:16];
      if (sel_q[3]) bank3[idx_q] <= wdata_q[31:24];
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with one wait state, one with none.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, data_i;
  logic [3:0]  sel;
  logic [31:0] data_o;
  logic        stallreq;

  logic        ce0, we0;
  logic [31:0] addr0, data_i0;
  logic [3:0]  sel0;
  logic [31:0] data_o0;
  logic        stallreq0;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .stallreq(stallreq)
  );

  data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce0), .we(we0), .addr(addr0), .sel(sel0),
    .data_i(data_i0), .data_o(data_o0), .stallreq(stallreq0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word1(input logic [9:0] i);
    return {u_dut.bank3[i], u_dut.bank2[i], u_dut.bank1[i], u_dut.bank0[i]};
  endfunction

  // One access on the WAIT_CYCLES=1 instance; inputs are scrambled once BUSY
  // to show the latched copy governs. Returns the number of BUSY cycles and
  // leaves the bench at the DONE negedge.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output int busy);
    @(negedge clk);
    we = w; addr = a; sel = s; data_i = d; ce = 1'b1;
    #1 check("req_stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    we = ~w; addr = ~a; sel = ~s; data_i = ~d;
    busy = 0;
    while (stallreq && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    check("done_state", 32'(u_dut.state_q), 32'd2);
    ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        w0v [4];
    logic [31:0] a0v [4];
    logic [31:0] d0v [4];
    w0v = '{1'b1, 1'b1, 1'b0, 1'b0};
    a0v = '{32'h0, 32'h8, 32'h0, 32'h8};
    d0v = '{32'hA0A0A0A0, 32'h0B0B0B0B, 32'hA0A0A0A0, 32'h0B0B0B0B};

    rst = 1'b0; ce = 1'b1; we = 1'b0; addr = '0; sel = '0; data_i = '0;
    ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = 4'hF; data_i0 = '0;

    // Reset holds everything idle even with ce asserted.
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stallreq), 32'd0);
    check("rst_data", data_o, 32'h0);
    check("rst_state", 32'(u_dut.state_q), 32'd0);
    check("rst_cnt", 32'(u_dut.cnt_q), 32'd0);
    ce = 1'b0; rst = 1'b1;

    // Full-word store then load at index 0.
    do_access(1'b1, 32'h0, 4'hF, 32'h00001234, n);
    check("st0_busy", n, 32'd2);
    check("st0_word", word1(10'd0), 32'h00001234);
    do_access(1'b0, 32'h0, 4'h0, 32'h0, n);
    check("ld0_busy", n, 32'd2);
    check("ld0_data", data_o, 32'h00001234);

    // Partial store merges into an existing word; stores leave data_o alone.
    do_access(1'b1, 32'h4, 4'hF, 32'h11223344, n);
    do_access(1'b1, 32'h4, 4'h3, 32'hFFFF89AB, n);
    check("st_keeps_data", data_o, 32'h00001234);
    do_access(1'b0, 32'h4, 4'h0, 32'h0, n);
    check("ld1_merge", data_o, 32'h112289AB);

    // Empty byte mask: normal timing, nothing written.
    do_access(1'b1, 32'h4, 4'h0, 32'hDEADBEEF, n);
    check("sel0_busy", n, 32'd2);
    check("sel0_word", word1(10'd1), 32'h112289AB);
    repeat (3) @(negedge clk);
    check("data_hold", data_o, 32'h112289AB);

    // Top index, read back through an aliased address with junk low bits.
    do_access(1'b1, 32'h00000FFC, 4'hF, 32'hCAFEF00D, n);
    check("top_word", word1(10'd1023), 32'hCAFEF00D);
    do_access(1'b0, 32'h80001FFF, 4'h0, 32'h0, n);
    check("alias_data", data_o, 32'hCAFEF00D);

    // Flush: ce drops in BUSY, store aborted.
    @(negedge clk);
    we = 1'b1; addr = 32'h0; sel = 4'hF; data_i = 32'h00000BAD; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    check("flush_state", 32'(u_dut.state_q), 32'd0);
    check("flush_stall", 32'(stallreq), 32'd0);
    check("flush_word", word1(10'd0), 32'h00001234);
    check("flush_data", data_o, 32'hCAFEF00D);

    // Reset asserted during BUSY of a store.
    we = 1'b1; addr = 32'h0; sel = 4'hF; data_i = 32'h00005555; ce = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_data", data_o, 32'h0);
    check("midrst_stall", 32'(stallreq), 32'd0);
    check("midrst_state", 32'(u_dut.state_q), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_word", word1(10'd0), 32'h00001234);
    ce = 1'b0; rst = 1'b1;
    do_access(1'b0, 32'h0, 4'h0, 32'h0, n);
    check("postrst_busy", n, 32'd2);
    check("postrst_data", data_o, 32'h00001234);

    // Zero wait states, ce held high across back-to-back accesses.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      we0 = w0v[k]; addr0 = a0v[k]; data_i0 = d0v[k]; ce0 = 1'b1;
      #1;
      check("w0_idle_state", 32'(u_dut0.state_q), 32'd0);
      check("w0_req_stall", 32'(stallreq0), 32'd1);
      @(negedge clk);
      check("w0_busy_stall", 32'(stallreq0), 32'd1);
      @(negedge clk);
      check("w0_done_stall", 32'(stallreq0), 32'd0);
      check("w0_done_state", 32'(u_dut0.state_q), 32'd2);
      if (!w0v[k]) check("w0_ld_data", data_o0, d0v[k]);
    end
    ce0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
